spi_adc_scanner: RTL and testbench

- Autonomous Avalon-side master for the 8-bit SPI master peripheral (CPOL0/CPHA0, MSB first, one slave).
- Scans NUM_CH channels of an MCP3008-class 10-bit ADC without CPU involvement. Each conversion is 3 SPI bytes framed by a held SS_n.
- Delivers {channel, sample} words downstream to the drum-hit detection logic.
- Sits directly upstream of the SPI master's register port, replacing the CPU as its bus master.

---
 rtl/spi_adc_scanner.sv | 269 ++++++++++++++++++++++++++
 tb/tb_spi_adc_scanner.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_scanner.sv
// spi_adc_scanner: autonomous bus master for the SPI register port.
// Scans an MCP3008-class ADC channel by channel and emits {ch, sample}.
module spi_adc_scanner #(
    parameter int NUM_CH     = 8,
    parameter int SCAN_GAP   = 50000,
    parameter int RX_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        spi_select,
    output logic [2:0]  spi_addr,
    output logic        spi_read_n,
    output logic        spi_write_n,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata,
    input  logic        spi_dataavailable,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [9:0]  sample_data,
    output logic        scan_done,
    output logic        timeout_err,
    output logic        busy
);

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    localparam int WW = $clog2(RX_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(RX_TIMEOUT);
    localparam logic [WW-1:0] WAIT_MIN = WW'(2);

    localparam int GW = (SCAN_GAP < 4) ? 2 : $clog2(SCAN_GAP);
    localparam logic [GW-1:0] GAP_LAST =
        (SCAN_GAP < 2) ? '0 : GW'(SCAN_GAP - 2);

    typedef enum logic [3:0] {
        IDLE,
        SS_SEL,
        CLR_ST,
        SSO_ON,
        TX,
        WAIT_RX,
        RX,
        SSO_OFF,
        EMIT,
        GAP
    } state_t;

    state_t state;
    state_t next;

    logic [1:0]    phase;
    logic [1:0]    k;
    logic [2:0]    ch;
    logic [1:0]    rx1;
    logic [7:0]    rx2;
    logic [WW-1:0] wcnt;
    logic [GW-1:0] gcnt;
    logic          skip;

    logic          is_acc;
    logic          acc_end;
    logic          rx_go;
    logic          to_hit;
    logic [15:0]   tx_word;

    // Only the low byte of the receive register carries ADC data.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^spi_rdata[15:8];

    // A register access is two strobed cycles plus one idle cycle.
    assign is_acc = (state == SS_SEL) || (state == CLR_ST) ||
                    (state == SSO_ON) || (state == TX) ||
                    (state == RX) || (state == SSO_OFF);
    assign acc_end = is_acc && (phase == 2'd2);

    // RRDY is ignored for the first two wait cycles so a stale flag
    // from the register pipeline cannot be mistaken for fresh data.
    assign rx_go  = (wcnt >= WAIT_MIN) && spi_dataavailable;
    assign to_hit = !rx_go && (wcnt >= WAIT_MAX);

    // Command bytes: start bit, single-ended + channel, then dummy.
    always_comb begin
        tx_word = 16'h0000;
        if (k == 2'd0) begin
            tx_word = 16'h0001;
        end else if (k == 2'd1) begin
            tx_word = {8'h00, 1'b1, ch, 4'b0000};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state decision.
    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (enable) next = SS_SEL;
            end
            SS_SEL: begin
                if (acc_end) next = CLR_ST;
            end
            CLR_ST: begin
                if (acc_end) next = SSO_ON;
            end
            SSO_ON: begin
                if (acc_end) next = TX;
            end
            TX: begin
                if (acc_end) next = WAIT_RX;
            end
            WAIT_RX: begin
                if (rx_go) begin
                    next = RX;
                end else if (to_hit) begin
                    next = SSO_OFF;
                end
            end
            RX: begin
                if (acc_end) begin
                    next = (k == 2'd2) ? SSO_OFF : TX;
                end
            end
            SSO_OFF: begin
                if (acc_end) next = EMIT;
            end
            EMIT: begin
                if (!enable) begin
                    next = IDLE;
                end else if (ch == LAST_CH) begin
                    next = (SCAN_GAP < 2) ? IDLE : GAP;
                end else begin
                    next = CLR_ST;
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) next = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    // Bus strobes and result pulses decoded from state and phase.
    always_comb begin
        spi_select   = 1'b0;
        spi_read_n   = 1'b1;
        spi_write_n  = 1'b1;
        spi_addr     = 3'd0;
        spi_wdata    = 16'h0000;
        sample_valid = 1'b0;
        scan_done    = 1'b0;
        busy         = (state != IDLE);
        if (is_acc && (phase != 2'd2)) begin
            spi_select = 1'b1;
            if (state == RX) begin
                spi_read_n = 1'b0;
            end else begin
                spi_write_n = 1'b0;
            end
            unique case (state)
                SS_SEL: begin
                    spi_addr  = 3'd5;
                    spi_wdata = 16'h0001;
                end
                CLR_ST: begin
                    spi_addr = 3'd2;
                end
                SSO_ON: begin
                    spi_addr  = 3'd3;
                    spi_wdata = 16'h0400;
                end
                TX: begin
                    spi_addr  = 3'd1;
                    spi_wdata = tx_word;
                end
                RX: begin
                    spi_addr = 3'd0;
                end
                SSO_OFF: begin
                    spi_addr = 3'd3;
                end
                default: begin
                end
            endcase
        end
        if (state == EMIT) begin
            sample_valid = !skip;
            scan_done    = enable && (ch == LAST_CH);
        end
    end

    // Access phase, wait/gap counters, byte index and channel tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= 2'd0;
            k           <= 2'd0;
            ch          <= 3'd0;
            rx1         <= 2'd0;
            rx2         <= 8'd0;
            wcnt        <= '0;
            gcnt        <= '0;
            skip        <= 1'b0;
            timeout_err <= 1'b0;
            sample_ch   <= 3'd0;
            sample_data <= 10'd0;
        end else begin
            if (!is_acc || acc_end) begin
                phase <= 2'd0;
            end else begin
                phase <= phase + 2'd1;
            end

            if (state == WAIT_RX) begin
                wcnt <= wcnt + 1'b1;
            end else begin
                wcnt <= '0;
            end

            if (state == GAP) begin
                gcnt <= gcnt + 1'b1;
            end else begin
                gcnt <= '0;
            end

            if (state == CLR_ST) begin
                k <= 2'd0;
            end else if ((state == RX) && acc_end && (k != 2'd2)) begin
                k <= k + 2'd1;
            end

            // Read data is captured at the end of the second strobe cycle.
            if ((state == RX) && (phase == 2'd1)) begin
                if (k == 2'd1) rx1 <= spi_rdata[1:0];
                if (k == 2'd2) rx2 <= spi_rdata[7:0];
            end

            if ((state == WAIT_RX) && to_hit) begin
                skip        <= 1'b1;
                timeout_err <= 1'b1;
            end

            // Load the result as EMIT is entered so it is valid with the pulse.
            if ((state == SSO_OFF) && acc_end && !skip) begin
                sample_ch   <= ch;
                sample_data <= {rx1, rx2};
            end

            if (state == EMIT) begin
                skip <= 1'b0;
                if (!enable || (ch == LAST_CH)) begin
                    ch <= 3'd0;
                end else begin
                    ch <= ch + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// tb_spi_adc_scanner: directed bench with an SPI register-port model,
// a bus protocol checker and a sample scoreboard.
module tb_spi_adc_scanner;

    localparam int NUM_CH     = 8;
    localparam int SCAN_GAP   = 20;
    localparam int RX_TIMEOUT = 4096;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        spi_select;
    logic [2:0]  spi_addr;
    logic        spi_read_n;
    logic        spi_write_n;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;
    logic        spi_dataavailable;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [9:0]  sample_data;
    logic        scan_done;
    logic        timeout_err;
    logic        busy;

    spi_adc_scanner #(
        .NUM_CH     (NUM_CH),
        .SCAN_GAP   (SCAN_GAP),
        .RX_TIMEOUT (RX_TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .spi_select        (spi_select),
        .spi_addr          (spi_addr),
        .spi_read_n        (spi_read_n),
        .spi_write_n       (spi_write_n),
        .spi_wdata         (spi_wdata),
        .spi_rdata         (spi_rdata),
        .spi_dataavailable (spi_dataavailable),
        .sample_valid      (sample_valid),
        .sample_ch         (sample_ch),
        .sample_data       (sample_data),
        .scan_done         (scan_done),
        .timeout_err       (timeout_err),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [19:0] log_acc[$];
    int          log_cyc[$];
    logic [13:0] sb[$];

    logic [9:0]  adc[8];
    logic [19:0] exp_seq[10];

    int          cyc = 0;
    int          lowcnt = 0;
    bit          last_rd = 0;
    int          m_bi = 0;
    bit          m_sso = 0;
    logic [2:0]  m_ch = 0;
    logic [7:0]  m_pend = 0;
    int          m_delay = 0;
    int          stuck_ch = 8;
    int          last_cmd_ch = -1;
    int          n_scan = 0;
    int          scan_cyc = 0;
    bit          to_seen = 0;
    int          to_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input bit last, input int c);
        logic [2:0] c3;
        c3 = 3'(c);
        sb.push_back({last, c3, adc[c3]});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_select"}, {31'b0, spi_select}, 0);
        check({tag, "_read_n"}, {31'b0, spi_read_n}, 1);
        check({tag, "_write_n"}, {31'b0, spi_write_n}, 1);
        check({tag, "_addr"}, {29'b0, spi_addr}, 0);
        check({tag, "_wdata"}, {16'b0, spi_wdata}, 0);
        check({tag, "_valid"}, {31'b0, sample_valid}, 0);
        check({tag, "_ch"}, {29'b0, sample_ch}, 0);
        check({tag, "_data"}, {22'b0, sample_data}, 0);
        check({tag, "_scan_done"}, {31'b0, scan_done}, 0);
        check({tag, "_timeout"}, {31'b0, timeout_err}, 0);
        check({tag, "_busy"}, {31'b0, busy}, 0);
    endtask

    // SPI register-port model, access protocol checker and sample monitor.
    always @(negedge clk) begin
        logic       strobe;
        logic [7:0] nxt;
        logic [9:0] v;
        logic [2:0] wc;
        logic [13:0] e;
        cyc++;
        if (!reset_n) begin
            lowcnt            = 0;
            m_bi              = 0;
            m_sso             = 0;
            m_delay           = 0;
            spi_dataavailable = 1'b0;
            spi_rdata         = 16'h0000;
        end else begin
            strobe = spi_select && (!spi_write_n || !spi_read_n);
            if (strobe) begin
                check("rw_overlap", {31'b0, (!spi_write_n && !spi_read_n)}, 0);
                lowcnt++;
                if (lowcnt == 1) begin
                    last_rd = !spi_read_n;
                    log_acc.push_back({!spi_read_n, spi_addr,
                                       spi_read_n ? spi_wdata : 16'h0000});
                    log_cyc.push_back(cyc);
                    if (!spi_read_n) begin
                        check("sso_held_rx", {31'b0, m_sso}, 1);
                    end else if (spi_addr == 3'd3) begin
                        m_sso = spi_wdata[10];
                        if (spi_wdata[10]) m_bi = 0;
                    end else if (spi_addr == 3'd1) begin
                        check("sso_held_tx", {31'b0, m_sso}, 1);
                        wc = spi_wdata[6:4];
                        if (m_bi == 0) begin
                            nxt = 8'h00;
                        end else if (m_bi == 1) begin
                            m_ch        = wc;
                            last_cmd_ch = int'(wc);
                            v           = adc[wc];
                            nxt         = {6'b000000, v[9:8]};
                        end else begin
                            v   = adc[m_ch];
                            nxt = v[7:0];
                        end
                        m_pend = nxt;
                        if (!(m_bi == 1 && int'(wc) == stuck_ch)) m_delay = 8;
                        m_bi++;
                    end
                end
            end else begin
                if (lowcnt != 0) begin
                    check("strobe_len", lowcnt, 2);
                    if (last_rd) spi_dataavailable = 1'b0;
                end
                lowcnt = 0;
            end
            if (m_delay > 0) begin
                m_delay--;
                if (m_delay == 0) begin
                    spi_rdata         = {8'hC3, m_pend};
                    spi_dataavailable = 1'b1;
                end
            end
            if (scan_done) begin
                n_scan++;
                scan_cyc = cyc;
            end
            if (timeout_err && !to_seen) begin
                to_seen = 1;
                to_cyc  = cyc;
            end
            if (sample_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_sample", {29'b0, sample_ch}, 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("sample_ch", {29'b0, sample_ch}, {29'b0, e[12:10]});
                    check("sample_data", {22'b0, sample_data}, {22'b0, e[9:0]});
                    check("scan_done_with_sample", {31'b0, scan_done},
                          {31'b0, e[13]});
                end
            end
        end
    end

    initial begin
        int L;
        int idx;
        int d;
        reset_n           = 1'b0;
        enable            = 1'b0;
        spi_rdata         = 16'h0000;
        spi_dataavailable = 1'b0;
        adc[0] = 10'h2A5;
        for (int c = 1; c < 8; c++) adc[c] = 10'(10'h3F0 + c);
        exp_seq[0] = 20'h50001;
        exp_seq[1] = 20'h20000;
        exp_seq[2] = 20'h30400;
        exp_seq[3] = 20'h10001;
        exp_seq[4] = 20'h80000;
        exp_seq[5] = 20'h10080;
        exp_seq[6] = 20'h80000;
        exp_seq[7] = 20'h10000;
        exp_seq[8] = 20'h80000;
        exp_seq[9] = 20'h30000;

        repeat (3) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (3) tick();
        check("idle_no_access", log_acc.size(), 0);

        // Pass 1: full scan, ch0 frame sequence and pass timing.
        for (int c = 0; c < NUM_CH; c++) push_exp(c == NUM_CH - 1, c);
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (n_scan >= 1) break;
            tick();
        end
        check("pass1_scan_done", n_scan, 1);
        check("pass1_sb_empty", sb.size(), 0);
        for (int i = 0; i < 10; i++) begin
            if (i < log_acc.size()) begin
                check($sformatf("ch0_access_%0d", i), {12'b0, log_acc[i]},
                      {12'b0, exp_seq[i]});
            end else begin
                check($sformatf("ch0_access_%0d_missing", i), log_acc.size(), 10);
            end
        end
        check("pass1_no_timeout", {31'b0, timeout_err}, 0);

        // Pass 2: restart timing, then ch3 never signals data.
        stuck_ch = 3;
        for (int c = 0; c < NUM_CH; c++) begin
            if (c != 3) push_exp(c == NUM_CH - 1, c);
        end
        L = log_acc.size();
        for (int i = 0; i < 200; i++) begin
            if (log_acc.size() > L) break;
            tick();
        end
        if (log_acc.size() > L) begin
            check("pass2_first_access", {12'b0, log_acc[L]}, 32'h50001);
            check("pass_gap_cycles", log_cyc[L] - scan_cyc, SCAN_GAP + 1);
        end else begin
            check("pass2_start_missing", log_acc.size(), L + 1);
        end
        for (int i = 0; i < 12000; i++) begin
            if (n_scan >= 2) break;
            tick();
        end
        check("pass2_scan_done", n_scan, 2);
        check("pass2_sb_empty", sb.size(), 0);
        check("timeout_err_set", {31'b0, timeout_err}, 1);
        idx = -1;
        for (int i = L; i < log_acc.size(); i++) begin
            if (idx < 0 && log_acc[i] == 20'h100B0) idx = i;
        end
        check("ch3_cmd_found", {31'b0, (idx >= 0)}, 1);
        if (idx >= 0 && idx + 1 < log_acc.size()) begin
            check("timeout_sso_off", {12'b0, log_acc[idx + 1]}, 32'h30000);
            d = to_cyc - log_cyc[idx];
            check("timeout_latency", {31'b0, (d >= RX_TIMEOUT && d <= RX_TIMEOUT + 14)}, 1);
        end
        stuck_ch = 8;

        // Pass 3: enable dropped during ch5 byte 1.
        for (int c = 0; c <= 5; c++) push_exp(0, c);
        for (int i = 0; i < 2000; i++) begin
            if (last_cmd_ch == 5) break;
            tick();
        end
        check("ch5_cmd_seen", last_cmd_ch, 5);
        enable = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!busy) break;
            tick();
        end
        check("drop_busy_low", {31'b0, busy}, 0);
        check("drop_sb_empty", sb.size(), 0);
        check("drop_no_scan_done", n_scan, 2);
        check("drop_sso_released", {31'b0, m_sso}, 0);
        L = log_acc.size();
        repeat (30) tick();
        check("disabled_no_access", log_acc.size(), L);

        // Pass 4: re-enable restarts at ch0, then reset during WAIT_RX.
        push_exp(0, 0);
        enable = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (last_cmd_ch == 1) break;
            tick();
        end
        check("reenable_ch1_cmd", last_cmd_ch, 1);
        if (log_acc.size() > L) begin
            check("reenable_ss_sel", {12'b0, log_acc[L]}, 32'h50001);
        end
        check("reenable_ch0_sample", sb.size(), 0);
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) tick();
        push_exp(0, 0);
        L = log_acc.size();
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (log_acc.size() > L) break;
            tick();
        end
        if (log_acc.size() > L) begin
            check("post_reset_ss_sel", {12'b0, log_acc[L]}, 32'h50001);
        end else begin
            check("post_reset_access_missing", log_acc.size(), L + 1);
        end
        enable = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!busy) break;
            tick();
        end
        check("final_busy_low", {31'b0, busy}, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
